rom_raster_reader: RTL and testbench
====================================

// Module: rom_raster_reader
// PURPOSE
//  Read initiator for the synchronous image ROM (1-cycle read latency, en-gated).
//  On start, issues addresses 0..WIDTH*HEIGHT-1 in raster order and presents the
//  returned pixels as a valid/ready stream tagged with x/y and frame markers.
//  Sits between the image ROM and the filament/sunspot detection pipeline. A
//  3-entry output FIFO absorbs the ROM latency and downstream backpressure.
// PARAMETERS
//  WIDTH    256  image width in pixels
//  HEIGHT   256  image height in pixels
//  PIXEL_W  8    bits per pixel
//  ADDR_W   16   ROM address width, >= log2(WIDTH*HEIGHT)
//  X_W      8    x-coordinate width, >= log2(WIDTH)
//  Y_W      8    y-coordinate width, >= log2(HEIGHT)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        1-cycle pulse; begin frame read (ignored unless IDLE)
//  busy       out  1        high from accepted start until done pulse
//  done       out  1        1-cycle pulse after last pixel handshake
//  rom_en     out  1        ROM read enable
//  rom_addr   out  ADDR_W   ROM read address
//  rom_data   in   PIXEL_W  ROM data, valid the cycle after rom_en
//  pix_valid  out  1        output pixel valid
//  pix_ready  in   1        downstream ready; transfer when valid&&ready
//  pix_data   out  PIXEL_W  pixel value
//  pix_x      out  X_W      column of pix_data
//  pix_y      out  Y_W      row of pix_data
//  pix_sof    out  1        high with pixel (0,0)
//  pix_eol    out  1        high with x==WIDTH-1
//  pix_eof    out  1        high with last pixel (WIDTH-1,HEIGHT-1)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; FIFO empty; address/coordinate counters 0.
//  FSM: IDLE -(start)-> READ -(last addr issued)-> DRAIN -(FIFO empty, no read in
//   flight)-> IDLE with done=1 that cycle. busy=1 in READ and DRAIN.
//  Issue: rom_en=1 in READ iff (fifo_count + inflight) < 3, inflight = rom_en
//   registered. No combinational path from pix_ready to rom_en/rom_addr.
//  rom_addr increments by 1 per issued read, starting at 0. rom_addr holds its
//   last value when rom_en=0. Each read's x/y/sof/eol/eof tags go down a 1-stage
//   pipe alongside it.
//  Capture: the cycle after rom_en=1, rom_data plus tags are pushed into the FIFO.
//   Push is guaranteed non-overflowing by the issue rule.
//  Output: pix_* = FIFO head; pix_valid = FIFO non-empty; pop on valid&&ready.
//   pix_* hold stable while valid&&!ready.
//  Latency: start high in cycle 0 -> rom_en/addr 0 in cycle 1 -> pix_valid in
//   cycle 3. With pix_ready held high: 1 pixel/clk, last pixel in cycle
//   3+WIDTH*HEIGHT-1, done in the following cycle.
//  Coordinates: x wraps WIDTH-1 -> 0 with y+1. Widths are sized so that no
//   counter overflows within a frame.
//  Boundaries: start during busy is ignored (no restart). Simultaneous push and
//   pop keeps fifo_count unchanged. Full FIFO with ready low stalls issue; no
//   pixel is lost or duplicated. WIDTH*HEIGHT==1 is supported (sof=eol=eof on a
//   single pixel).
//  rst_n low mid-frame: immediate return to IDLE, FIFO flushed, rom_en=0,
//   pix_valid=0, no done pulse.
// TESTING
//  1 4x2 image, ROM = addr+0x10, ready=1, start@c0 -> rom_en c1..c8,
//    pix_valid c3..c10, data 0x10..0x17, done@c11.
//  2 Same image, ready toggles 1/0 -> 8 pixels in order, no drop or duplicate;
//    data/x/y stable while stalled; fifo_count never exceeds 3.
//  3 ready=0 for 10 cycles after start -> rom_en asserts exactly 3 times, then
//    resumes on ready=1; output sequence unchanged.
//  4 Markers on 4x2: sof only on (0,0); eol on x=3 of both rows; eof only on
//    (3,1); x/y match addr = y*4+x.
//  5 Second start pulse while busy -> ignored; exactly one done pulse and 8
//    pixels.
//  6 rst_n low after 3 pixels -> outputs 0 asynchronously, IDLE; new start
//    restarts at addr 0 with sof.

Source files
------------

// File: rtl/rom_raster_reader.sv
// rom_raster_reader: raster-order reader for a 1-cycle-latency image ROM, streaming tagged pixels through a 3-entry FIFO
//   clk, rst_n          clock, asynchronous active-low reset
//   start, busy, done   frame request pulse, frame in progress, end-of-frame pulse
//   rom_en, rom_addr    ROM read request; rom_data returns the cycle after rom_en
//   pix_valid/ready     output handshake; pix_data/x/y/sof/eol/eof are the FIFO head
module rom_raster_reader #(
   parameter int WIDTH   = 256,
   parameter int HEIGHT  = 256,
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 16,
   parameter int X_W     = 8,
   parameter int Y_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               rom_en,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [PIXEL_W-1:0] rom_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [PIXEL_W-1:0] pix_data,
   output logic [X_W-1:0]     pix_x,
   output logic [Y_W-1:0]     pix_y,
   output logic               pix_sof,
   output logic               pix_eol,
   output logic               pix_eof
);
   localparam int E_W = PIXEL_W + X_W + Y_W + 3;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state;
   logic [X_W-1:0] x, tx;
   logic [Y_W-1:0] y, ty;
   logic tsof, teol, teof, inflight, sof, eol, eof, push, pop;
   logic [1:0] count;
   logic [E_W-1:0] mem [3];
   assign sof = x == '0 && y == '0;
   assign eol = x == X_W'(WIDTH - 1);
   assign eof = eol && y == Y_W'(HEIGHT - 1);
   // issue only from registered occupancy so pix_ready never reaches rom_en
   assign rom_en = state == READ && (3'(count) + 3'(inflight)) < 3'd3;
   assign push = inflight;
   assign pop = pix_valid && pix_ready;
   assign pix_valid = count != 2'd0;
   assign {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof} = mem[0];
   assign busy = state != IDLE;
   assign done = state == DRAIN && count == 2'd0 && !inflight;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rom_addr <= '0;
         x <= '0;
         y <= '0;
         inflight <= 1'b0;
         {tx, ty, tsof, teol, teof} <= '0;
         count <= 2'd0;
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else begin
         inflight <= rom_en;
         if (rom_en) {tx, ty, tsof, teol, teof} <= {x, y, sof, eol, eof};
         if (state == IDLE && start) begin
            state <= READ;
            rom_addr <= '0;
            x <= '0;
            y <= '0;
         end else if (rom_en) begin
            if (eof) state <= DRAIN;
            else begin
               rom_addr <= rom_addr + 1'b1;
               x <= eol ? '0 : x + 1'b1;
               y <= eol ? y + 1'b1 : y;
            end
         end else if (done) state <= IDLE;
         count <= count + 2'(push) - 2'(pop);
         // head-at-0 shift FIFO; a push lands just behind the surviving entries
         if (pop) begin
            mem[0] <= mem[1];
            mem[1] <= mem[2];
         end
         if (push) mem[pop ? count - 2'd1 : count] <= {rom_data, tx, ty, tsof, teol, teof};
      end
   end
endmodule

// File: tb/tb_rom_raster_reader.sv
// tb_rom_raster_reader: scoreboard bench for rom_raster_reader on a 4x2 image with ROM = addr + 0x10
module tb_rom_raster_reader;
   logic clk, rst_n, start, busy, done, rom_en, pix_valid, pix_ready;
   logic pix_sof, pix_eol, pix_eof;
   logic [15:0] rom_addr;
   logic [7:0] rom_data, pix_data, pix_x, pix_y;
   typedef struct packed {logic [7:0] d; logic [7:0] x; logic [7:0] y; logic sof; logic eol; logic eof;} px_t;
   px_t q[$];
   int errors = 0, checks = 0, n_en = 0, n_pop = 0, n_done = 0;
   logic stall = 1'b0;
   logic [23:0] held = '0;
   rom_raster_reader #(.WIDTH(4), .HEIGHT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) if (rom_en) rom_data <= 8'(rom_addr) + 8'h10;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         n_en = 0;
         n_pop = 0;
         stall = 1'b0;
      end else begin
         if (busy) chk("occupancy_le_3", 64'(n_en - n_pop <= 3), 1);
         if (stall) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_hold", {pix_data, pix_x, pix_y}, held);
         end
         if (pix_valid && pix_ready) begin
            checks++;
            assert (q.size() != 0) else begin
               errors++;
               $error("FAIL extra_pixel observed=%0h expected=none", pix_data);
            end
            if (q.size() != 0) begin
               px_t e;
               e = q.pop_front();
               chk("pix_data", pix_data, e.d);
               chk("pix_xy", {pix_x, pix_y}, {e.x, e.y});
               chk("pix_markers", {pix_sof, pix_eol, pix_eof}, {e.sof, e.eol, e.eof});
            end
            n_pop++;
         end
         stall = pix_valid && !pix_ready;
         held = {pix_data, pix_x, pix_y};
         if (rom_en) n_en++;
         if (done) n_done++;
      end
   end
   task automatic push_frame();
      for (int a = 0; a < 8; a++) begin
         px_t e;
         e.d = 8'(a + 16);
         e.x = 8'(a % 4);
         e.y = 8'(a / 4);
         e.sof = a == 0;
         e.eol = a % 4 == 3;
         e.eof = a == 7;
         q.push_back(e);
      end
   endtask
   task automatic send_start();
      push_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic wait_done(input int mode, input string tag);
      int d0 = n_done;
      for (int k = 0; k < 200 && n_done == d0; k++) begin
         if (mode == 1) pix_ready = ~pix_ready;
         if (mode == 2) start = k == 3;
         @(posedge clk); #1;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_count"}, 64'(n_done - d0), 1);
      chk({tag, "_all_out"}, 64'(q.size()), 0);
   endtask
   initial begin
      logic [15:0] en_m, val_m, dn_m;
      int base, d0;
      rst_n = 1'b0;
      start = 1'b0;
      pix_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {busy, done, rom_en, pix_valid, rom_addr, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // latency and throughput with ready held high
      push_frame();
      d0 = n_done;
      start = 1'b1;
      en_m = '0;
      val_m = '0;
      dn_m = '0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         en_m[k] = rom_en;
         val_m[k] = pix_valid;
         dn_m[k] = done;
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("lat_rom_en_cycles", en_m, 16'h01FE);
      chk("lat_valid_cycles", val_m, 16'h07F8);
      chk("lat_done_cycle", dn_m, 16'h0800);
      chk("lat_done_count", 64'(n_done - d0), 1);
      chk("lat_all_out", 64'(q.size()), 0);
      chk("idle_after_frame", busy, 0);
      // ready toggling every cycle
      send_start();
      wait_done(1, "toggle");
      // ready low after start: issue stops at three reads
      pix_ready = 1'b0;
      base = n_en;
      send_start();
      repeat (10) @(posedge clk);
      #1;
      chk("stall_issue_count", 64'(n_en - base), 3);
      chk("stall_fifo_valid", pix_valid, 1);
      chk("stall_rom_en_low", rom_en, 0);
      pix_ready = 1'b1;
      wait_done(0, "stall_resume");
      // second start while busy is ignored
      send_start();
      wait_done(2, "restart_ignored");
      // reset mid-frame after three pixels
      base = n_pop;
      send_start();
      for (int k = 0; k < 50 && n_pop - base < 3; k++) begin
         @(posedge clk); #1;
      end
      chk("mid_three_popped", 64'(n_pop - base >= 3), 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {busy, done, rom_en, pix_valid, rom_addr}, 0);
      q.delete();
      d0 = n_done;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("no_done_on_reset", 64'(n_done - d0), 0);
      send_start();
      wait_done(0, "after_reset");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
